// File: rtl/ifetch_ctrl.sv
// ifetch_ctrl: instruction fetch sequencer.
// Steps the PC register through load/offset pulses, issues one instruction
// memory request at a time, and hands each fetched word to decode over a
// valid/ready handshake. Redirects from execute flush any fetch in flight.
// All outputs come straight from registers.

module ifetch_ctrl #(
    parameter int WORD_SIZE = 32
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic [WORD_SIZE-1:0] i_pc_value,
    output logic                 o_pc_load,
    output logic                 o_pc_offset,
    output logic [WORD_SIZE-1:0] o_pc_data,
    output logic                 o_imem_req,
    output logic [WORD_SIZE-1:0] o_imem_addr,
    input  logic                 i_imem_ack,
    input  logic [WORD_SIZE-1:0] i_imem_rdata,
    output logic [WORD_SIZE-1:0] o_instr,
    output logic                 o_instr_valid,
    input  logic                 i_instr_ready,
    input  logic                 i_redirect,
    input  logic [WORD_SIZE-1:0] i_redirect_target,
    input  logic                 i_halt
);

    localparam logic [WORD_SIZE-1:0] PC_STEP = {{(WORD_SIZE-1){1'b0}}, 1'b1};
    localparam logic [WORD_SIZE-1:0] ZERO_W  = {WORD_SIZE{1'b0}};

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_REQ   = 3'd1,
        S_DRAIN = 3'd2,
        S_ISSUE = 3'd3,
        S_HALT  = 3'd4
    } state_t;

    state_t               r_state;
    state_t               w_state_nxt;

    logic                 r_pc_load;
    logic                 r_pc_offset;
    logic [WORD_SIZE-1:0] r_pc_data;
    logic                 r_imem_req;
    logic [WORD_SIZE-1:0] r_imem_addr;
    logic [WORD_SIZE-1:0] r_instr;
    logic                 r_instr_valid;

    logic                 w_pc_load_nxt;
    logic                 w_pc_offset_nxt;
    logic [WORD_SIZE-1:0] w_pc_data_nxt;
    logic                 w_imem_req_nxt;
    logic [WORD_SIZE-1:0] w_imem_addr_nxt;
    logic [WORD_SIZE-1:0] w_instr_nxt;
    logic                 w_instr_valid_nxt;

    // A redirect is only honoured outside HALT; HALT is left by reset alone.
    logic                 w_redirect;
    // PC is still settling while a load or offset pulse is on the wire.
    logic                 w_pc_busy;

    assign w_redirect = i_redirect && (r_state != S_HALT);
    assign w_pc_busy  = r_pc_load || r_pc_offset;

    assign o_pc_load     = r_pc_load;
    assign o_pc_offset   = r_pc_offset;
    assign o_pc_data     = r_pc_data;
    assign o_imem_req    = r_imem_req;
    assign o_imem_addr   = r_imem_addr;
    assign o_instr       = r_instr;
    assign o_instr_valid = r_instr_valid;

    // State register.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state selection; redirect outranks every other transition.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_redirect || w_pc_busy) begin
                    w_state_nxt = S_IDLE;
                end else if (i_halt) begin
                    w_state_nxt = S_HALT;
                end else begin
                    w_state_nxt = S_REQ;
                end
            end
            S_REQ: begin
                if (w_redirect) begin
                    w_state_nxt = i_imem_ack ? S_IDLE : S_DRAIN;
                end else if (i_imem_ack) begin
                    w_state_nxt = S_ISSUE;
                end else begin
                    w_state_nxt = S_REQ;
                end
            end
            S_DRAIN: begin
                if (i_imem_ack) begin
                    w_state_nxt = S_IDLE;
                end else begin
                    w_state_nxt = S_DRAIN;
                end
            end
            S_ISSUE: begin
                if (w_redirect || i_instr_ready) begin
                    w_state_nxt = S_IDLE;
                end else begin
                    w_state_nxt = S_ISSUE;
                end
            end
            S_HALT: begin
                w_state_nxt = S_HALT;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Next values of the registered outputs for the coming cycle.
    always_comb begin
        w_pc_load_nxt     = 1'b0;
        w_pc_offset_nxt   = 1'b0;
        w_pc_data_nxt     = r_pc_data;
        w_imem_req_nxt    = r_imem_req;
        w_imem_addr_nxt   = r_imem_addr;
        w_instr_nxt       = r_instr;
        w_instr_valid_nxt = r_instr_valid;
        case (r_state)
            S_IDLE: begin
                w_imem_req_nxt    = 1'b0;
                w_instr_valid_nxt = 1'b0;
                if (w_redirect || w_pc_busy) begin
                    w_imem_addr_nxt = r_imem_addr;
                end else if (i_halt) begin
                    w_imem_addr_nxt = ZERO_W;
                    w_pc_data_nxt   = ZERO_W;
                end else begin
                    w_imem_addr_nxt = i_pc_value;
                    w_imem_req_nxt  = 1'b1;
                end
            end
            S_REQ: begin
                if (i_imem_ack) begin
                    w_imem_req_nxt = 1'b0;
                    if (!w_redirect) begin
                        w_instr_nxt       = i_imem_rdata;
                        w_instr_valid_nxt = 1'b1;
                        w_pc_offset_nxt   = 1'b1;
                        w_pc_data_nxt     = PC_STEP;
                    end else begin
                        w_instr_nxt = r_instr;
                    end
                end else begin
                    w_imem_req_nxt = 1'b1;
                end
            end
            S_DRAIN: begin
                if (i_imem_ack) begin
                    w_imem_req_nxt = 1'b0;
                end else begin
                    w_imem_req_nxt = 1'b1;
                end
            end
            S_ISSUE: begin
                if (w_redirect || i_instr_ready) begin
                    w_instr_valid_nxt = 1'b0;
                end else begin
                    w_instr_valid_nxt = 1'b1;
                end
            end
            S_HALT: begin
                w_pc_data_nxt     = ZERO_W;
                w_imem_req_nxt    = 1'b0;
                w_imem_addr_nxt   = ZERO_W;
                w_instr_valid_nxt = 1'b0;
            end
            default: begin
                w_pc_data_nxt     = ZERO_W;
                w_imem_req_nxt    = 1'b0;
                w_imem_addr_nxt   = ZERO_W;
                w_instr_valid_nxt = 1'b0;
            end
        endcase
        // Redirect overrides: load pulse, no offset, kill the pending word.
        if (w_redirect) begin
            w_pc_load_nxt     = 1'b1;
            w_pc_data_nxt     = i_redirect_target;
            w_pc_offset_nxt   = 1'b0;
            w_instr_valid_nxt = 1'b0;
        end else begin
            w_pc_load_nxt = 1'b0;
        end
    end

    // Output registers.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_pc_load     <= 1'b0;
            r_pc_offset   <= 1'b0;
            r_pc_data     <= ZERO_W;
            r_imem_req    <= 1'b0;
            r_imem_addr   <= ZERO_W;
            r_instr       <= ZERO_W;
            r_instr_valid <= 1'b0;
        end else begin
            r_pc_load     <= w_pc_load_nxt;
            r_pc_offset   <= w_pc_offset_nxt;
            r_pc_data     <= w_pc_data_nxt;
            r_imem_req    <= w_imem_req_nxt;
            r_imem_addr   <= w_imem_addr_nxt;
            r_instr       <= w_instr_nxt;
            r_instr_valid <= w_instr_valid_nxt;
        end
    end

endmodule

// File: tb/tb_ifetch_ctrl.sv
// Testbench for ifetch_ctrl: models the PC register and instruction memory,
// keeps an architectural PC and a queue of expected delivered words, and
// checks the DUT from a monitor sampling on the falling clock edge.

module tb_ifetch_ctrl;

    localparam int          W         = 32;
    localparam logic [31:0] PC_RESET  = 32'h0000_0010;

    logic          clk;
    logic          rst;
    logic [W-1:0]  pc_value;
    logic          pc_load;
    logic          pc_offset;
    logic [W-1:0]  pc_data;
    logic          imem_req;
    logic [W-1:0]  imem_addr;
    logic          imem_ack;
    logic [W-1:0]  imem_rdata;
    logic [W-1:0]  instr;
    logic          instr_valid;
    logic          instr_ready;
    logic          redirect;
    logic [W-1:0]  redirect_target;
    logic          halt;

    ifetch_ctrl #(.WORD_SIZE(W)) dut (
        .i_clk             (clk),
        .i_rst             (rst),
        .i_pc_value        (pc_value),
        .o_pc_load         (pc_load),
        .o_pc_offset       (pc_offset),
        .o_pc_data         (pc_data),
        .o_imem_req        (imem_req),
        .o_imem_addr       (imem_addr),
        .i_imem_ack        (imem_ack),
        .i_imem_rdata      (imem_rdata),
        .o_instr           (instr),
        .o_instr_valid     (instr_valid),
        .i_instr_ready     (instr_ready),
        .i_redirect        (redirect),
        .i_redirect_target (redirect_target),
        .i_halt            (halt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Memory contents are a fixed function of the address.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'hC0DE_0000;
    endfunction

    // Counters and model state
    int          n_pass = 0;
    int          n_total = 0;
    int          fixed_delay = 0;    // -1: random 0..4 wait cycles per request
    int          measure_period = 0; // 0: handshake spacing not checked
    int          last_hs = -1;
    int          cyc = 0;
    int          hs_count = 0;
    int          n_offset = 0;
    int          n_load = 0;
    int          n_req_rise = 0;
    bit          halted = 1'b0;
    logic [31:0] arch_pc = PC_RESET;
    logic [31:0] exp_q[$];
    bit          exp_load_v = 1'b0;
    logic [31:0] exp_load_d = 32'd0;
    bit          stall_prev = 1'b0;
    logic [31:0] prev_instr = 32'd0;
    bit          prev_req = 1'b0;
    logic [31:0] prev_addr = 32'd0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic refill();
        exp_q.delete();
        exp_q.push_back(mem_word(arch_pc));
    endtask

    // PC register environment: load wins over offset.
    always @(posedge clk or posedge rst) begin
        if (rst) pc_value <= PC_RESET;
        else if (pc_load) pc_value <= pc_data;
        else if (pc_offset) pc_value <= pc_value + pc_data;
    end

    // Instruction memory: per-request wait cycles, one-cycle ack.
    initial begin : memory
        int wait_left;
        wait_left  = -1;
        imem_ack   = 1'b0;
        imem_rdata = 32'd0;
        forever begin
            @(posedge clk);
            #2;
            imem_ack   = 1'b0;
            imem_rdata = $urandom;
            if (rst || !imem_req) begin
                wait_left = -1;
            end else begin
                if (wait_left < 0)
                    wait_left = (fixed_delay >= 0) ? fixed_delay : int'($urandom_range(0, 4));
                if (wait_left == 0) begin
                    imem_ack   = 1'b1;
                    imem_rdata = mem_word(imem_addr);
                    wait_left  = -1;
                end else begin
                    wait_left--;
                end
            end
        end
    end

    // Monitor: checks this cycle against the model, then advances the model.
    initial begin : monitor
        forever begin
            @(negedge clk);
            cyc++;
            if (rst) begin
                chk("rst_ctrl", {28'd0, pc_load, pc_offset, imem_req, instr_valid}, 32'd0);
                chk("rst_pc_data", pc_data, 32'd0);
                chk("rst_imem_addr", imem_addr, 32'd0);
                chk("rst_instr", instr, 32'd0);
                arch_pc    = PC_RESET;
                refill();
                exp_load_v = 1'b0;
                stall_prev = 1'b0;
                prev_req   = 1'b0;
                prev_addr  = 32'd0;
                last_hs    = -1;
            end else begin
                chk("load_offset_excl", {31'd0, pc_load & pc_offset}, 32'd0);
                chk("pc_load_pulse", {31'd0, pc_load}, {31'd0, exp_load_v});
                if (pc_load) n_load++;
                if (pc_load && exp_load_v) chk("pc_load_data", pc_data, exp_load_d);
                if (pc_offset) begin
                    n_offset++;
                    chk("pc_offset_data", pc_data, 32'd1);
                end
                if (instr_valid) chk("no_req_while_valid", {31'd0, imem_req}, 32'd0);
                if (stall_prev) begin
                    chk("stall_valid", {31'd0, instr_valid}, 32'd1);
                    chk("stall_instr", instr, prev_instr);
                end
                if (imem_req && !prev_req) begin
                    n_req_rise++;
                    chk("req_addr", imem_addr, arch_pc);
                end
                if (imem_req && prev_req) chk("req_addr_stable", imem_addr, prev_addr);
                if (halted) begin
                    chk("halt_ctrl", {28'd0, pc_load, pc_offset, imem_req, instr_valid}, 32'd0);
                    chk("halt_pc_data", pc_data, 32'd0);
                    chk("halt_imem_addr", imem_addr, 32'd0);
                end
                if (instr_valid && instr_ready) begin
                    if (exp_q.size() == 0) begin
                        chk("instr_unexpected", instr, 32'hDEAD_BEEF);
                    end else begin
                        chk("instr_word", instr, exp_q.pop_front());
                    end
                    if (measure_period > 0 && last_hs >= 0)
                        chk("fetch_period", cyc - last_hs, measure_period);
                    last_hs = cyc;
                    hs_count++;
                    arch_pc = arch_pc + 32'd1;
                    refill();
                end
                exp_load_v = redirect && !halted;
                exp_load_d = redirect_target;
                if (redirect && !halted) begin
                    arch_pc = redirect_target;
                    refill();
                end
                stall_prev = instr_valid && !instr_ready && !redirect;
                prev_instr = instr;
                prev_req   = imem_req;
                prev_addr  = imem_addr;
            end
        end
    end

    // Bounded wait for imem_req (sel=0) or instr_valid (sel=1) to reach val.
    task automatic wait_sig(input int sel, input logic val, input int budget, input string name);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(posedge clk);
            #3;
            if (((sel == 0) ? imem_req : instr_valid) === val) begin
                ok = 1'b1;
                break;
            end
        end
        chk(name, {31'd0, ok}, 32'd1);
    endtask

    task automatic wait_hs(input int target, input int budget, input string name);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(posedge clk);
            #3;
            if (hs_count >= target) begin
                ok = 1'b1;
                break;
            end
        end
        chk(name, {31'd0, ok}, 32'd1);
    endtask

    initial begin : watchdog
        #400000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    // Stimulus sequence
    initial begin : stimulus
        int off0;
        int rq0;
        int h0;
        int ld0;
        rst = 1'b1; instr_ready = 1'b1; redirect = 1'b0;
        redirect_target = 32'd0; halt = 1'b0;
        repeat (3) @(posedge clk);
        #3 rst = 1'b0;

        // First request after reset targets the reset PC
        wait_sig(0, 1'b1, 3, "reset_first_req");
        chk("reset_first_addr", imem_addr, PC_RESET);

        // Zero-wait straight fetch: one instruction every 3 cycles
        measure_period = 3; last_hs = -1;
        h0 = hs_count;
        wait_hs(h0 + 5, 40, "straight_progress");

        // Memory with 2 wait cycles: period 5
        fixed_delay = 2; measure_period = 5; last_hs = -1;
        h0 = hs_count;
        wait_hs(h0 + 4, 60, "wait2_progress");
        measure_period = 0;

        // Backpressure: five stalled cycles in ISSUE
        fixed_delay = 0;
        wait_sig(1, 1'b0, 10, "bp_sync");
        instr_ready = 1'b0;
        wait_sig(1, 1'b1, 10, "bp_valid");
        off0 = n_offset; rq0 = n_req_rise;
        repeat (5) @(posedge clk);
        #3;
        chk("bp_offset_pulses", n_offset - off0, 1);
        chk("bp_no_new_req", n_req_rise - rq0, 0);
        chk("bp_still_valid", {31'd0, instr_valid}, 32'd1);
        instr_ready = 1'b1;

        // Redirect while waiting on memory
        fixed_delay = 3;
        wait_sig(0, 1'b0, 10, "rdw_sync");
        wait_sig(0, 1'b1, 10, "rdw_req");
        redirect = 1'b1; redirect_target = 32'h0000_0040;
        @(posedge clk);
        #3 redirect = 1'b0;
        wait_sig(0, 1'b0, 10, "rdw_drain");
        wait_sig(0, 1'b1, 10, "rdw_next_req");
        chk("rdw_next_addr", imem_addr, 32'h0000_0040);

        // Redirect in the ack cycle
        fixed_delay = 0;
        wait_sig(0, 1'b0, 10, "rda_sync");
        wait_sig(0, 1'b1, 10, "rda_req");
        redirect = 1'b1; redirect_target = 32'h0000_0080;
        off0 = n_offset;
        @(posedge clk);
        #3 redirect = 1'b0;
        wait_sig(0, 1'b1, 10, "rda_next_req");
        chk("rda_next_addr", imem_addr, 32'h0000_0080);
        chk("rda_no_offset", n_offset - off0, 0);

        // Randomized traffic
        fixed_delay = -1;
        h0 = hs_count;
        for (int i = 0; i < 800; i++) begin
            @(posedge clk);
            #3;
            instr_ready     = ($urandom_range(0, 3) != 0);
            redirect        = ($urandom_range(0, 9) == 0);
            redirect_target = $urandom;
        end
        redirect = 1'b0; instr_ready = 1'b1;
        chk("random_progress", {31'd0, (hs_count - h0) > 20}, 32'd1);

        // Asynchronous reset in the middle of a request
        fixed_delay = 4;
        wait_sig(0, 1'b0, 20, "rst_sync");
        wait_sig(0, 1'b1, 10, "rst_req");
        #1 rst = 1'b1;
        #1;
        chk("async_rst_req", {31'd0, imem_req}, 32'd0);
        chk("async_rst_addr", imem_addr, 32'd0);
        repeat (2) @(posedge clk);
        #3 rst = 1'b0;
        wait_sig(0, 1'b1, 3, "rst_release_req");
        chk("rst_release_addr", imem_addr, PC_RESET);

        // Halt, ignored redirect, reset out of halt
        fixed_delay = 0; halt = 1'b1;
        repeat (20) @(posedge clk);
        #3 halted = 1'b1;
        ld0 = n_load; rq0 = n_req_rise;
        redirect = 1'b1; redirect_target = 32'h0000_0055;
        @(posedge clk);
        #3 redirect = 1'b0;
        repeat (10) @(posedge clk);
        #3;
        chk("halt_no_load", n_load - ld0, 0);
        chk("halt_no_req", n_req_rise - rq0, 0);
        rst = 1'b1; halted = 1'b0; halt = 1'b0;
        @(posedge clk);
        #3 rst = 1'b0;
        wait_sig(0, 1'b1, 3, "halt_exit_req");
        chk("halt_exit_addr", imem_addr, PC_RESET);

        repeat (10) @(posedge clk);
        #3;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
